run_length_detector: RTL

- Multi-channel, run-length event detector for serial bit streams, e.g. line-idle, stuck-at and preamble detection on sampled input pins.
- Each channel counts consecutive equal-valued samples, 1s or 0s.
- Raises a tick when the run reaches a runtime-programmable threshold.
- Three tick modes: level, single pulse, periodic. Sampling is qualified by a shared valid strobe.

---
 rtl/run_det_pkg.sv | 17 +
 rtl/run_length_detector_if.sv | 24 ++
 rtl/run_det_channel.sv | 106 ++++++++++
 rtl/run_length_detector.sv | 41 ++++
 4 files changed

// File: rtl/run_det_pkg.sv
// Shared types and constants for the run-length detector.
// Holds the tick mode encoding and the saturation limit derivation.
package run_det_pkg;

  typedef enum logic [1:0] {
    MODE_LEVEL    = 2'd0,
    MODE_PULSE    = 2'd1,
    MODE_PERIODIC = 2'd2,
    MODE_RSVD     = 2'd3
  } run_mode_t;

  // Largest run a counter of cnt_w bits can hold before saturating.
  function automatic int max_run(input int cnt_w);
    return (32'sd1 << cnt_w) - 32'sd1;
  endfunction

endpackage

// File: rtl/run_length_detector_if.sv
// Sample/config inputs and detect outputs of the run-length detector.
// The master drives the streams; the slave (the detector) returns ticks.
interface run_length_detector_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
);
  logic                      valid;
  logic [CHANNELS-1:0]       din;
  logic [CNT_W-1:0]          threshold;
  logic [1:0]                mode;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       tick_pol;
  logic [CHANNELS*CNT_W-1:0] run_len;

  modport master (
    output valid, din, threshold, mode,
    input  tick, tick_pol, run_len
  );

  modport slave (
    input  valid, din, threshold, mode,
    output tick, tick_pol, run_len
  );
endinterface

// File: rtl/run_det_channel.sv
// One channel: tracks the current run (value, saturating length, phase)
// and produces a registered tick according to the shared mode.
module run_det_channel
  import run_det_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic             din,
  input  logic [CNT_W-1:0] threshold,
  input  run_mode_t        mode,
  output logic             tick,
  output logic             tick_pol,
  output logic [CNT_W-1:0] run_len
);

  localparam logic [CNT_W-1:0] MAX_RUN = CNT_W'(max_run(CNT_W));
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};

  logic             last_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] phase_r;
  logic             tick_r;
  logic             pol_r;

  logic             nlast_s;
  logic [CNT_W-1:0] ncnt_s;
  logic [CNT_W-1:0] nphase_s;
  logic [CNT_W-1:0] ocnt_s;
  logic             armed_s;
  logic             tick_nxt_s;
  logic             pol_nxt_s;

  // Next run state; ocnt_s is the old count seen from inside the new run.
  always_comb begin
    nlast_s  = last_r;
    ncnt_s   = cnt_r;
    nphase_s = phase_r;
    ocnt_s   = cnt_r;
    if ((cnt_r == ZERO) || (din != last_r)) begin
      nlast_s  = din;
      ncnt_s   = ONE;
      nphase_s = ONE;
      ocnt_s   = ZERO;
    end else begin
      ncnt_s   = (cnt_r == MAX_RUN) ? MAX_RUN : (cnt_r + ONE);
      nphase_s = (phase_r == threshold) ? ONE : (phase_r + ONE);
    end
  end

  // Tick decision; without a qualified sample only level mode holds its tick.
  always_comb begin
    armed_s    = (threshold != ZERO);
    tick_nxt_s = 1'b0;
    pol_nxt_s  = pol_r;
    if (valid) begin
      case (mode)
        MODE_LEVEL:    tick_nxt_s = armed_s && (ncnt_s >= threshold);
        MODE_PULSE:    tick_nxt_s = armed_s && (ncnt_s >= threshold) && (ocnt_s < threshold);
        MODE_PERIODIC: tick_nxt_s = armed_s && (nphase_s == threshold);
        default:       tick_nxt_s = 1'b0;
      endcase
    end else begin
      case (mode)
        MODE_LEVEL: tick_nxt_s = tick_r;
        default:    tick_nxt_s = 1'b0;
      endcase
    end
    if (valid && tick_nxt_s) begin
      pol_nxt_s = nlast_s;
    end else begin
      pol_nxt_s = pol_r;
    end
  end

  // Run state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r  <= 1'b0;
      cnt_r   <= ZERO;
      phase_r <= ZERO;
      tick_r  <= 1'b0;
      pol_r   <= 1'b0;
    end else begin
      if (valid) begin
        last_r  <= nlast_s;
        cnt_r   <= ncnt_s;
        phase_r <= nphase_s;
      end else begin
        last_r  <= last_r;
        cnt_r   <= cnt_r;
        phase_r <= phase_r;
      end
      tick_r <= tick_nxt_s;
      pol_r  <= pol_nxt_s;
    end
  end

  assign tick     = tick_r;
  assign tick_pol = pol_r;
  assign run_len  = cnt_r;

endmodule

// File: rtl/run_length_detector.sv
// Multi-channel run-length event detector: fans shared controls out to
// independent per-channel detectors and packs their run counts.
module run_length_detector
  import run_det_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  run_length_detector_if.slave  bus
);

  logic [CHANNELS-1:0]       tick_s;
  logic [CHANNELS-1:0]       pol_s;
  logic [CHANNELS*CNT_W-1:0] run_len_s;
  run_mode_t                 mode_s;

  assign mode_s = run_mode_t'(bus.mode);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    run_det_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .valid     (bus.valid),
      .din       (bus.din[i]),
      .threshold (bus.threshold),
      .mode      (mode_s),
      .tick      (tick_s[i]),
      .tick_pol  (pol_s[i]),
      .run_len   (run_len_s[i*CNT_W +: CNT_W])
    );
  end

  assign bus.tick     = tick_s;
  assign bus.tick_pol = pol_s;
  assign bus.run_len  = run_len_s;

endmodule
